// File: rtl/lane_judge.sv
// Four-lane hit judgement: key sync/edge detect, per-lane GOOD/BAD/PUSH state
// with hold timer, and score / combo / max-combo bookkeeping.
module lane_judge #(
    parameter int DW       = 481,
    parameter int HIT_IDX  = 384,
    parameter int WIN      = 8,
    parameter int HOLD_CYC = 2500000,
    parameter int GOOD_PTS = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wait_,
    input  logic          on_off,
    input  logic [3:0]    key,
    input  logic [DW-1:0] drop_1,
    input  logic [DW-1:0] drop_2,
    input  logic [DW-1:0] drop_3,
    input  logic [DW-1:0] drop_4,
    output logic [2:0]    down_0,
    output logic [2:0]    down_1,
    output logic [2:0]    down_2,
    output logic [2:0]    down_3,
    output logic [3:0]    hit,
    output logic [15:0]   score,
    output logic [9:0]    combo,
    output logic [9:0]    max_combo
);

    localparam int LO = HIT_IDX - WIN;
    localparam int HI = HIT_IDX + WIN;
    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    if (HIT_IDX < WIN || HIT_IDX + WIN > DW - 1) begin : g_bad_window
        $fatal(1, "lane_judge: judgement window falls outside the drop vector");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_GOOD = 2'd2,
        ST_BAD  = 2'd3
    } lane_st_e;

    logic [3:0]    key_s1, key_s2, key_prev;
    logic [3:0]    press, in_win;
    logic [3:0]    good_d, bad_d;
    lane_st_e      st_q  [4];
    lane_st_e      st_d  [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [2:0]    good_cnt;
    logic [31:0]   score_sum;
    logic [10:0]   combo_sum;
    logic [15:0]   score_d;
    logic [9:0]    combo_d, max_d;

    // Only the window slice matters; the rest of each drop vector is display data.
    logic unused_drop_bits;
    assign unused_drop_bits = ^{drop_1, drop_2, drop_3, drop_4};

    assign in_win[0] = |drop_1[HI:LO];
    assign in_win[1] = |drop_2[HI:LO];
    assign in_win[2] = |drop_3[HI:LO];
    assign in_win[3] = |drop_4[HI:LO];

    // NOTE: every flop uses non-blocking assignment so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
        end else if (wait_) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign press = key_s2 & ~key_prev & {4{on_off}};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        good_d = '0;
        bad_d  = '0;
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (press[i]) begin
                st_d[i]   = in_win[i] ? ST_GOOD : ST_BAD;
                cnt_d[i]  = CW'(HOLD_CYC - 1);
                good_d[i] = in_win[i];
                bad_d[i]  = ~in_win[i];
            end else begin
                unique case (st_q[i])
                    ST_GOOD, ST_BAD: begin
                        if (cnt_q[i] == '0) begin
                            st_d[i] = key_s2[i] ? ST_PUSH : ST_IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                    ST_PUSH: begin
                        if (!key_s2[i]) begin
                            st_d[i] = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A BAD anywhere this cycle breaks the combo even if other lanes scored.
    always_comb begin
        good_cnt  = 3'($countones(good_d));
        score_sum = 32'(score) + 32'(GOOD_PTS) * 32'(good_cnt);
        score_d   = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
        combo_sum = 11'(combo) + 11'(good_cnt);
        if (|bad_d) begin
            combo_d = '0;
        end else if (combo_sum > 11'd1023) begin
            combo_d = 10'd1023;
        end else begin
            combo_d = combo_sum[9:0];
        end
        max_d = (combo_d > max_combo) ? combo_d : max_combo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
            hit       <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else if (wait_) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
            hit       <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            hit       <= good_d;
            score     <= score_d;
            combo     <= combo_d;
            max_combo <= max_d;
        end
    end

    assign down_0 = {1'b0, st_q[0]};
    assign down_1 = {1'b0, st_q[1]};
    assign down_2 = {1'b0, st_q[2]};
    assign down_3 = {1'b0, st_q[3]};

endmodule

// File: tb/tb_lane_judge.sv
// Self-checking bench for lane_judge: window table, directed timing sequences,
// saturation run and randomized traffic against a rule-level reference model.
module tb_lane_judge;

    localparam int DW       = 481;
    localparam int HIT_IDX  = 384;
    localparam int WIN      = 2;
    localparam int HOLD_CYC = 4;
    localparam int GOOD_PTS = 10;

    logic          clk = 1'b0;
    logic          rst, wait_, on_off;
    logic [3:0]    key;
    logic [DW-1:0] drops [4];
    logic [2:0]    down_0, down_1, down_2, down_3;
    logic [3:0]    hit;
    logic [15:0]   score;
    logic [9:0]    combo, max_combo;

    lane_judge #(
        .DW(DW), .HIT_IDX(HIT_IDX), .WIN(WIN), .HOLD_CYC(HOLD_CYC), .GOOD_PTS(GOOD_PTS)
    ) dut (
        .clk(clk), .rst(rst), .wait_(wait_), .on_off(on_off), .key(key),
        .drop_1(drops[0]), .drop_2(drops[1]), .drop_3(drops[2]), .drop_4(drops[3]),
        .down_0(down_0), .down_1(down_1), .down_2(down_2), .down_3(down_3),
        .hit(hit), .score(score), .combo(combo), .max_combo(max_combo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lane codes, absolute expiry cycle of each judgement,
    // totals as plain integers, and a short history of driven key values.
    int         m_code   [4];
    int         m_expire [4];
    int         m_score, m_combo, m_max;
    logic [3:0] m_hit;
    logic [3:0] kh [3];
    int         cyc = 0;

    typedef struct {
        int lane;
        int pos;
        int code;
        int score;
        int combo;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_code[i]   = 0;
            m_expire[i] = 0;
        end
        for (int j = 0; j < 3; j++) kh[j] = '0;
        m_score = 0;
        m_combo = 0;
        m_max   = 0;
        m_hit   = '0;
    endtask

    // Predicts the state after the next rising edge from the inputs now applied.
    task automatic model_step();
        int         gc;
        bit         any_bad;
        bit         on_note;
        logic [3:0] held, press;
        cyc++;
        if (rst || wait_) begin
            model_clear();
            return;
        end
        held    = kh[1];
        press   = kh[1] & ~kh[2];
        gc      = 0;
        any_bad = 0;
        m_hit   = '0;
        for (int i = 0; i < 4; i++) begin
            on_note = 0;
            for (int b = HIT_IDX - WIN; b <= HIT_IDX + WIN; b++)
                if (drops[i][b] === 1'b1) on_note = 1;
            if (on_off && press[i]) begin
                m_code[i]   = on_note ? 2 : 3;
                m_expire[i] = cyc + HOLD_CYC;
                if (on_note) begin
                    gc++;
                    m_hit[i] = 1'b1;
                end else begin
                    any_bad = 1;
                end
            end else if (m_code[i] >= 2 && cyc == m_expire[i]) begin
                m_code[i] = held[i] ? 1 : 0;
            end else if (m_code[i] == 1 && !held[i]) begin
                m_code[i] = 0;
            end
        end
        m_score = m_score + GOOD_PTS * gc;
        if (m_score > 65535) m_score = 65535;
        if (any_bad) m_combo = 0;
        else m_combo = (m_combo + gc > 1023) ? 1023 : m_combo + gc;
        if (m_combo > m_max) m_max = m_combo;
        kh[2] = kh[1];
        kh[1] = kh[0];
        kh[0] = key;
    endtask

    task automatic compare_all(input string tag);
        logic [11:0] exp_d;
        for (int i = 0; i < 4; i++) exp_d[i*3 +: 3] = 3'(m_code[i]);
        check({tag, " down"}, 32'({down_3, down_2, down_1, down_0}), 32'(exp_d));
        check({tag, " hit"}, 32'(hit), 32'(m_hit));
        check({tag, " score"}, 32'(score), m_score);
        check({tag, " combo"}, 32'(combo), m_combo);
        check({tag, " max_combo"}, 32'(max_combo), m_max);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic do_clear();
        key    = '0;
        on_off = 1'b1;
        for (int i = 0; i < 4; i++) drops[i] = '0;
        wait_ = 1'b1;
        cycle("clear");
        wait_ = 1'b0;
        check("clear score", 32'(score), 0);
    endtask

    function automatic logic [2:0] lane_down(input int l);
        case (l)
            0:       return down_0;
            1:       return down_1;
            2:       return down_2;
            default: return down_3;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 382, 2, 10, 1};
        vecs[1] = '{1, 384, 2, 10, 1};
        vecs[2] = '{1, 386, 2, 10, 1};
        vecs[3] = '{1, 381, 3, 0, 0};
        vecs[4] = '{1, 387, 3, 0, 0};
        vecs[5] = '{1, -1, 3, 0, 0};
        vecs[6] = '{2, 0, 3, 0, 0};
        vecs[7] = '{3, 480, 3, 0, 0};
        vecs[8] = '{0, 383, 2, 10, 1};

        rst    = 1'b1;
        wait_  = 1'b0;
        on_off = 1'b1;
        key    = '0;
        for (int i = 0; i < 4; i++) drops[i] = '0;
        model_clear();
        cycles("reset", 3);
        check("reset downs", 32'({down_3, down_2, down_1, down_0}), 0);
        check("reset score", 32'(score), 0);
        check("reset max_combo", 32'(max_combo), 0);
        rst = 1'b0;

        // Hit in window, hold to PUSH, release to IDLE.
        do_clear();
        drops[0][386] = 1'b1;
        key = 4'b0001;
        cycles("t2 sync", 2);
        check("t2 not yet judged", 32'(down_0), 0);
        cycle("t2 judge");
        check("t2 down_0 good", 32'(down_0), 2);
        check("t2 hit pulse", 32'(hit), 1);
        check("t2 score", 32'(score), 10);
        check("t2 combo", 32'(combo), 1);
        cycle("t2 hold");
        check("t2 hit one cycle", 32'(hit), 0);
        cycles("t2 hold", 2);
        check("t2 still good", 32'(down_0), 2);
        cycle("t2 expire");
        check("t2 push", 32'(down_0), 1);
        key = 4'b0000;
        cycles("t2 release", 2);
        check("t2 push until s2 low", 32'(down_0), 1);
        cycle("t2 release");
        check("t2 idle", 32'(down_0), 0);

        // Window boundary table.
        foreach (vecs[v]) begin
            do_clear();
            if (vecs[v].pos >= 0) drops[vecs[v].lane][vecs[v].pos] = 1'b1;
            key[vecs[v].lane] = 1'b1;
            cycles("tbl", 3);
            check($sformatf("tbl%0d code", v), 32'(lane_down(vecs[v].lane)), vecs[v].code);
            check($sformatf("tbl%0d hit", v), 32'(hit),
                  (vecs[v].code == 2) ? (1 << vecs[v].lane) : 0);
            check($sformatf("tbl%0d score", v), 32'(score), vecs[v].score);
            check($sformatf("tbl%0d combo", v), 32'(combo), vecs[v].combo);
            key = '0;
            cycles("tbl idle", 2);
        end

        // Miss after a GOOD: combo cleared, score and max_combo retained.
        do_clear();
        drops[1][382] = 1'b1;
        key = 4'b0010;
        cycles("t3 good", 3);
        check("t3 combo 1", 32'(combo), 1);
        drops[1] = '0;
        drops[1][387] = 1'b1;
        key = 4'b0000;
        cycles("t3 release", 2);
        key = 4'b0010;
        cycles("t3 miss", 3);
        check("t3 bad code", 32'(down_1), 3);
        check("t3 combo cleared", 32'(combo), 0);
        check("t3 score kept", 32'(score), 10);
        check("t3 max kept", 32'(max_combo), 1);

        // Simultaneous lanes.
        do_clear();
        drops[0][384] = 1'b1;
        drops[1][383] = 1'b1;
        drops[2][385] = 1'b1;
        key = 4'b0111;
        cycles("t4 three", 3);
        check("t4 hit3", 32'(hit), 32'h7);
        check("t4 score30", 32'(score), 30);
        check("t4 combo3", 32'(combo), 3);
        key = 4'b0000;
        cycles("t4 release", 2);
        key = 4'b1011;
        cycles("t4 mixed", 3);
        check("t4 hit2", 32'(hit), 32'h3);
        check("t4 score50", 32'(score), 50);
        check("t4 combo0", 32'(combo), 0);
        check("t4 max3", 32'(max_combo), 3);
        check("t4 lane3 bad", 32'(down_3), 3);

        // Gating, clear coincident with press, re-press reload at hold expiry.
        do_clear();
        on_off = 1'b0;
        drops[0][384] = 1'b1;
        key = 4'b0001;
        cycles("t6 gated", 3);
        check("t6 gated down", 32'(down_0), 0);
        check("t6 gated score", 32'(score), 0);
        on_off = 1'b1;
        key = 4'b0000;
        cycles("t6 release", 2);
        key = 4'b0001;
        cycles("t6 arm", 2);
        wait_ = 1'b1;
        cycle("t6 wait");
        wait_ = 1'b0;
        check("t6 wait down", 32'(down_0), 0);
        check("t6 wait hit", 32'(hit), 0);
        cycles("t6 repress", 3);
        check("t6 good after clear", 32'(down_0), 2);
        key = 4'b0000;
        cycle("t6 drop key");
        key = 4'b0001;
        cycles("t6 reload", 3);
        check("t6 reload code", 32'(down_0), 2);
        check("t6 reload hit", 32'(hit), 1);
        check("t6 reload score", 32'(score), 20);
        check("t6 reload combo", 32'(combo), 2);
        cycles("t6 hold", 3);
        check("t6 held good", 32'(down_0), 2);
        cycle("t6 expire");
        check("t6 push", 32'(down_0), 1);

        // Asynchronous reset in the middle of a GOOD hold.
        do_clear();
        drops[2][384] = 1'b1;
        key = 4'b0100;
        cycles("t1 good", 4);
        check("t1 pre-reset", 32'(down_2), 2);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        compare_all("t1 async");
        check("t1 down_2 zero", 32'(down_2), 0);
        check("t1 score zero", 32'(score), 0);
        check("t1 combo zero", 32'(combo), 0);
        check("t1 no hit", 32'(hit), 0);
        cycle("t1 held");
        rst = 1'b0;
        key = 4'b0000;
        cycle("t1 release");

        // Saturation: key toggles every cycle, all lanes on the hit line.
        do_clear();
        for (int i = 0; i < 4; i++) drops[i][HIT_IDX] = 1'b1;
        for (int n = 0; n < 3400; n++) begin
            key = ~key;
            cycle("sat");
        end
        check("sat score", 32'(score), 65535);
        check("sat combo", 32'(combo), 1023);
        check("sat max", 32'(max_combo), 1023);

        // Randomized traffic near the window edges.
        do_clear();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) key = key ^ 4'($urandom);
            if ($urandom_range(5) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    drops[i] = '0;
                    for (int k = 0; k < int'($urandom_range(2)); k++)
                        drops[i][HIT_IDX - 4 + int'($urandom_range(8))] = 1'b1;
                end
            end
            on_off = ($urandom_range(9) != 0);
            wait_  = ($urandom_range(79) == 0);
            cycle("rnd");
        end
        wait_ = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
